// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register target.
`timescale 1ns/1ps
package spi_pkg;
    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} spi_tgt_state_t;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_MB_BIT = 6;
    localparam int SPI_BYTE_W = 8;
endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall strobes.
`timescale 1ns/1ps
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= {2{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_prev <= r_sync[1];
        end
    end

    assign o_level = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_prev;
    assign o_fall  = ~r_sync[1] & r_prev;
endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target with an 8-bit register file; sclk/cs_n/mosi are oversampled in the clk domain.
`timescale 1ns/1ps
module spi_target_regs
    import spi_pkg::*;
#(
    parameter int                    ADDR_W   = 6,
    parameter logic [SPI_BYTE_W-1:0] DEVID    = 8'hE5,
    parameter logic [ADDR_W-1:0]     RST_ADDR = ADDR_W'('h1D),
    parameter logic [SPI_BYTE_W-1:0] RST_CODE = 8'h52
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    output logic                  o_wr_valid,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [SPI_BYTE_W-1:0] o_wr_data,
    output logic                  o_frame_done
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = $clog2(SPI_BYTE_W);

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_sclk),
        .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_cs_n),
        .o_level(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk, w_cs_rise, w_cs_fall, w_mosi_rise, w_mosi_fall};

    spi_tgt_state_t                         r_state, w_state_nxt;
    logic [1:0]                             r_settle;
    logic                                   r_armed;
    logic [CNT_W-1:0]                       r_bit_cnt;
    logic [SPI_BYTE_W-2:0]                  r_shift_in;
    logic [SPI_BYTE_W-1:0]                  r_shift_out;
    logic                                   r_load_pend;
    logic                                   r_byte_seen;
    logic [ADDR_W-1:0]                      r_addr;
    logic                                   r_mb;
    logic                                   r_wr_valid;
    logic [ADDR_W-1:0]                      r_wr_addr;
    logic [SPI_BYTE_W-1:0]                  r_wr_data;
    logic                                   r_frame_done;
    logic [NUM_REGS-1:0][SPI_BYTE_W-1:0]    r_regs;

    logic [SPI_BYTE_W-1:0] w_byte_in;
    logic                  w_byte_done;
    logic                  w_soft_rst;
    logic [SPI_BYTE_W-1:0] w_rdata;

    assign w_byte_in   = {r_shift_in, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_state != IDLE) &&
                         (r_bit_cnt == CNT_W'(SPI_BYTE_W - 1));
    assign w_soft_rst  = (r_addr == RST_ADDR) && (w_byte_in == RST_CODE);
    assign w_rdata     = (r_addr == '0) ? DEVID : r_regs[r_addr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_armed && !w_cs_n) w_state_nxt = CMD;
            CMD:     if (w_byte_done) w_state_nxt = w_byte_in[CMD_RW_BIT] ? READ : WRITE;
            default: ;
        endcase
        if (r_state != IDLE && w_cs_n) w_state_nxt = IDLE;
    end

    // A frame already in progress when reset is released must be ignored, so
    // selection is only honoured after cs_n has been seen high post-reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_settle     <= '0;
            r_armed      <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= '0;
            r_load_pend  <= 1'b0;
            r_byte_seen  <= 1'b0;
            r_addr       <= '0;
            r_mb         <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_regs       <= '0;
        end else begin
            r_settle     <= {r_settle[0], 1'b1};
            r_wr_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_settle[1] && w_cs_n) r_armed <= 1'b1;

            if (r_state == IDLE) begin
                r_bit_cnt   <= '0;
                r_shift_in  <= '0;
                r_shift_out <= '0;
                r_load_pend <= 1'b0;
                r_byte_seen <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_shift_in <= w_byte_in[SPI_BYTE_W-2:0];
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                    if (w_byte_done) begin
                        r_byte_seen <= 1'b1;
                        case (r_state)
                            CMD: begin
                                r_addr      <= w_byte_in[ADDR_W-1:0];
                                r_mb        <= w_byte_in[CMD_MB_BIT];
                                r_load_pend <= w_byte_in[CMD_RW_BIT];
                            end
                            WRITE: begin
                                if (r_addr != '0) begin
                                    r_wr_valid <= 1'b1;
                                    r_wr_addr  <= r_addr;
                                    r_wr_data  <= w_byte_in;
                                    if (w_soft_rst) r_regs <= '0;
                                    else            r_regs[r_addr] <= w_byte_in;
                                end
                                if (r_mb) r_addr <= r_addr + 1'b1;
                            end
                            READ: begin
                                r_load_pend <= 1'b1;
                                if (r_mb) r_addr <= r_addr + 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                if (w_sclk_fall && r_state == READ) begin
                    if (r_load_pend) begin
                        r_shift_out <= w_rdata;
                        r_load_pend <= 1'b0;
                    end else begin
                        r_shift_out <= {r_shift_out[SPI_BYTE_W-2:0], 1'b0};
                    end
                end

                // Deselect: a byte completing in this same clk has already committed above.
                if (w_cs_n) begin
                    r_frame_done <= r_byte_seen | w_byte_done;
                    r_bit_cnt    <= '0;
                    r_shift_in   <= '0;
                    r_shift_out  <= '0;
                    r_load_pend  <= 1'b0;
                end
            end
        end
    end

    assign o_miso       = (r_state == READ) ? r_shift_out[SPI_BYTE_W-1] : 1'b0;
    assign o_miso_oe    = ~w_cs_n;
    assign o_wr_valid   = r_wr_valid;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_spi_target_regs.sv
// Self-checking bench for spi_target_regs: directed scenarios plus random frames vs a register-map model.
`timescale 1ns/1ps
module tb_spi_target_regs;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       i_reset_n, i_sclk, i_cs_n, i_mosi;
    logic       o_miso, o_miso_oe, o_wr_valid, o_frame_done;
    logic [5:0] o_wr_addr;
    logic [7:0] o_wr_data;

    always #5 clk = ~clk;

    spi_target_regs dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_wr_valid(o_wr_valid),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_frame_done(o_frame_done)
    );

    int tests = 0;
    int fails = 0;

    // Observed-event monitor (single writer for these counters)
    int         wr_cnt = 0, fd_cnt = 0, wr_wide = 0;
    logic [5:0] wr_a = '0;
    logic [7:0] wr_d = '0;
    logic       wr_prev = 1'b0;
    always @(negedge clk) begin
        if (o_wr_valid === 1'b1) begin
            if (wr_prev) wr_wide++;
            wr_cnt++;
            wr_a = o_wr_addr;
            wr_d = o_wr_data;
        end
        wr_prev = (o_wr_valid === 1'b1);
        if (o_frame_done === 1'b1) fd_cnt++;
    end

    // Reference model: register map as the host sees it
    bit [7:0] mregs [64];
    bit [7:0] tx_buf [8];
    bit [7:0] rx_buf [8];
    bit [7:0] exp_rx [8];
    int       exp_wr;
    bit [5:0] exp_wa;
    bit [7:0] exp_wd;

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
    endfunction

    function automatic void model_frame(input bit [7:0] cmd, input int n);
        int a;
        a = int'(cmd[5:0]);
        exp_wr = 0;
        for (int i = 0; i < n; i++) begin
            if (cmd[7]) begin
                exp_rx[i] = (a == 0) ? 8'hE5 : mregs[a];
            end else if (a != 0) begin
                exp_wr++;
                exp_wa = 6'(a);
                exp_wd = tx_buf[i];
                if (a == 'h1D && tx_buf[i] == 8'h52) model_clear();
                else mregs[a] = tx_buf[i];
            end
            if (cmd[6]) a = (a + 1) % 64;
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input bit b, output bit r);
        i_mosi = b;
        wait_clk(HALF);
        r = o_miso;
        i_sclk = 1'b1;
        wait_clk(HALF);
        i_sclk = 1'b0;
    endtask

    task automatic spi_byte(input bit [7:0] t, input int nbits, output bit [7:0] r);
        bit b;
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(t[7-i], b);
            r[7-i] = b;
        end
    endtask

    task automatic spi_start();
        i_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_stop();
        wait_clk(HALF);
        i_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Full frame: model updated, bytes from tx_buf, captured MISO bytes in rx_buf
    task automatic spi_frame(input bit [7:0] cmd, input int n);
        bit [7:0] r;
        model_frame(cmd, n);
        spi_start();
        spi_byte(cmd, 8, r);
        for (int i = 0; i < n; i++) begin
            spi_byte(tx_buf[i], 8, r);
            rx_buf[i] = r;
        end
        spi_stop();
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
        model_clear();
        wait_clk(4);
        i_reset_n = 1'b1;
        wait_clk(4);
        tests++; if (o_miso !== 1'b0)       begin fails++; $display("FAIL reset_miso got %b want 0", o_miso); end
        tests++; if (o_miso_oe !== 1'b0)    begin fails++; $display("FAIL reset_miso_oe got %b want 0", o_miso_oe); end
        tests++; if (o_wr_valid !== 1'b0)   begin fails++; $display("FAIL reset_wr_valid got %b want 0", o_wr_valid); end
        tests++; if (o_wr_addr !== 6'h00)   begin fails++; $display("FAIL reset_wr_addr got %h want 00", o_wr_addr); end
        tests++; if (o_wr_data !== 8'h00)   begin fails++; $display("FAIL reset_wr_data got %h want 00", o_wr_data); end
        tests++; if (o_frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", o_frame_done); end
    endtask

    task automatic test_devid_read();
        int w0, f0;
        w0 = wr_cnt; f0 = fd_cnt;
        spi_frame(8'h80, 1);
        tests++; if (rx_buf[0] !== 8'hE5) begin fails++; $display("FAIL devid_read got %h want e5", rx_buf[0]); end
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL devid_no_write got %0d want 0", wr_cnt - w0); end
        tests++; if (fd_cnt - f0 != 1) begin fails++; $display("FAIL devid_frame_done got %0d want 1", fd_cnt - f0); end
    endtask

    task automatic test_write_read();
        int w0;
        w0 = wr_cnt;
        tx_buf[0] = 8'h08;
        spi_frame(8'h2D, 1);
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL wr_count got %0d want 1", wr_cnt - w0); end
        tests++; if (wr_a !== 6'h2D)   begin fails++; $display("FAIL wr_addr got %h want 2d", wr_a); end
        tests++; if (wr_d !== 8'h08)   begin fails++; $display("FAIL wr_data got %h want 08", wr_d); end
        tests++; if (wr_wide != 0)     begin fails++; $display("FAIL wr_pulse_width wide pulses %0d want 0", wr_wide); end
        spi_frame(8'hAD, 1);
        tests++; if (rx_buf[0] !== 8'h08) begin fails++; $display("FAIL readback_2d got %h want 08", rx_buf[0]); end
    endtask

    task automatic test_mb_burst();
        int w0;
        w0 = wr_cnt;
        // 0x3F -> 0x00 (read-only, dropped) -> 0x01
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h5A; tx_buf[2] = 8'h22;
        spi_frame(8'h7F, 3);
        tests++; if (wr_cnt - w0 != 2) begin fails++; $display("FAIL mb_wr_count got %0d want 2", wr_cnt - w0); end
        tests++; if (wr_a !== 6'h01 || wr_d !== 8'h22) begin fails++; $display("FAIL mb_last_wr got %h/%h want 01/22", wr_a, wr_d); end
        spi_frame(8'hBF, 1);
        tests++; if (rx_buf[0] !== 8'h11) begin fails++; $display("FAIL mb_reg3f got %h want 11", rx_buf[0]); end
        spi_frame(8'h80, 1);
        tests++; if (rx_buf[0] !== 8'hE5) begin fails++; $display("FAIL mb_reg00 got %h want e5", rx_buf[0]); end
        spi_frame(8'h81, 1);
        tests++; if (rx_buf[0] !== 8'h22) begin fails++; $display("FAIL mb_reg01 got %h want 22", rx_buf[0]); end

        for (int i = 0; i < 6; i++) tx_buf[i] = 8'($urandom);
        spi_frame(8'h72, 6);
        spi_frame(8'hF2, 6);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (rx_buf[i] !== mregs[8'h32 + i]) begin
                fails++; $display("FAIL mb_read byte %0d got %h want %h", i, rx_buf[i], mregs[8'h32 + i]);
            end
        end
    endtask

    task automatic test_abort();
        int w0, f0;
        bit [7:0] r;
        tx_buf[0] = 8'h3C;
        spi_frame(8'h31, 1);
        w0 = wr_cnt; f0 = fd_cnt;
        spi_start();
        spi_byte(8'h31, 8, r);
        spi_byte(8'hA5, 5, r);
        spi_stop();
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL abort_no_write got %0d want 0", wr_cnt - w0); end
        tests++; if (fd_cnt - f0 != 1) begin fails++; $display("FAIL abort_frame_done got %0d want 1", fd_cnt - f0); end
        spi_frame(8'hB1, 1);
        tests++; if (rx_buf[0] !== 8'h3C) begin fails++; $display("FAIL abort_reg31 got %h want 3c", rx_buf[0]); end
        w0 = wr_cnt; f0 = fd_cnt;
        spi_start();
        spi_byte(8'h31, 5, r);
        spi_stop();
        tests++; if (fd_cnt - f0 != 0) begin fails++; $display("FAIL abort_cmd_frame_done got %0d want 0", fd_cnt - f0); end
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL abort_cmd_no_write got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_simultaneous();
        int w0, f0;
        bit [7:0] r;
        w0 = wr_cnt; f0 = fd_cnt;
        spi_start();
        spi_byte(8'h35, 8, r);
        spi_byte(8'h9C, 7, r);
        i_mosi = 1'b0;
        wait_clk(HALF);
        i_sclk = 1'b1;
        i_cs_n = 1'b1;
        wait_clk(HALF);
        i_sclk = 1'b0;
        wait_clk(2 * HALF);
        mregs[8'h35] = 8'h9C;
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL simul_wr_count got %0d want 1", wr_cnt - w0); end
        tests++; if (wr_a !== 6'h35 || wr_d !== 8'h9C) begin fails++; $display("FAIL simul_wr got %h/%h want 35/9c", wr_a, wr_d); end
        tests++; if (fd_cnt - f0 != 1) begin fails++; $display("FAIL simul_frame_done got %0d want 1", fd_cnt - f0); end
        spi_frame(8'hB5, 1);
        tests++; if (rx_buf[0] !== 8'h9C) begin fails++; $display("FAIL simul_readback got %h want 9c", rx_buf[0]); end
    endtask

    task automatic test_soft_reset();
        int w0;
        tx_buf[0] = 8'h08;
        spi_frame(8'h2D, 1);
        w0 = wr_cnt;
        tx_buf[0] = 8'h52;
        spi_frame(8'h1D, 1);
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL soft_wr_count got %0d want 1", wr_cnt - w0); end
        tests++; if (wr_a !== 6'h1D || wr_d !== 8'h52) begin fails++; $display("FAIL soft_wr got %h/%h want 1d/52", wr_a, wr_d); end
        spi_frame(8'hAD, 1);
        tests++; if (rx_buf[0] !== 8'h00) begin fails++; $display("FAIL soft_reg2d got %h want 00", rx_buf[0]); end
        spi_frame(8'h9D, 1);
        tests++; if (rx_buf[0] !== 8'h00) begin fails++; $display("FAIL soft_reg1d got %h want 00", rx_buf[0]); end
        spi_frame(8'hB5, 1);
        tests++; if (rx_buf[0] !== 8'h00) begin fails++; $display("FAIL soft_reg35 got %h want 00", rx_buf[0]); end
    endtask

    task automatic test_async_reset();
        int w0, f0;
        bit [7:0] r;
        tx_buf[0] = 8'h6B;
        spi_frame(8'h32, 1);
        spi_start();
        spi_byte(8'hB2, 8, r);
        spi_byte(8'h00, 4, r);
        tests++; if (r[7:4] !== 4'h6) begin fails++; $display("FAIL async_pre_nibble got %h want 6", r[7:4]); end
        tests++; if (o_miso_oe !== 1'b1) begin fails++; $display("FAIL async_pre_oe got %b want 1", o_miso_oe); end
        i_reset_n = 1'b0;
        #1;
        tests++; if (o_miso_oe !== 1'b0) begin fails++; $display("FAIL async_oe got %b want 0", o_miso_oe); end
        tests++; if (o_miso !== 1'b0)    begin fails++; $display("FAIL async_miso got %b want 0", o_miso); end
        wait_clk(3);
        i_reset_n = 1'b1;
        model_clear();
        w0 = wr_cnt; f0 = fd_cnt;
        // cs_n is still low: the rest of this frame must be ignored
        spi_byte(8'h00, 4, r);
        spi_byte(8'h32, 8, r);
        spi_byte(8'h77, 8, r);
        spi_stop();
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL async_ignored_write got %0d want 0", wr_cnt - w0); end
        tests++; if (fd_cnt - f0 != 0) begin fails++; $display("FAIL async_ignored_frame_done got %0d want 0", fd_cnt - f0); end
        spi_frame(8'hB2, 1);
        tests++; if (rx_buf[0] !== 8'h00) begin fails++; $display("FAIL async_reg32 got %h want 00", rx_buf[0]); end
        spi_frame(8'h80, 1);
        tests++; if (rx_buf[0] !== 8'hE5) begin fails++; $display("FAIL async_devid got %h want e5", rx_buf[0]); end
    endtask

    task automatic test_random_frames();
        int w0, f0, n;
        bit [7:0] cmd;
        for (int k = 0; k < 24; k++) begin
            cmd = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
            w0 = wr_cnt; f0 = fd_cnt;
            spi_frame(cmd, n);
            if (cmd[7]) begin
                for (int i = 0; i < n; i++) begin
                    tests++;
                    if (rx_buf[i] !== exp_rx[i]) begin
                        fails++; $display("FAIL rand_read cmd %h byte %0d got %h want %h", cmd, i, rx_buf[i], exp_rx[i]);
                    end
                end
            end
            tests++;
            if (wr_cnt - w0 != exp_wr) begin
                fails++; $display("FAIL rand_wr_count cmd %h got %0d want %0d", cmd, wr_cnt - w0, exp_wr);
            end
            if (exp_wr > 0) begin
                tests++;
                if (wr_a !== exp_wa || wr_d !== exp_wd) begin
                    fails++; $display("FAIL rand_last_wr cmd %h got %h/%h want %h/%h", cmd, wr_a, wr_d, exp_wa, exp_wd);
                end
            end
            tests++;
            if (fd_cnt - f0 != 1) begin
                fails++; $display("FAIL rand_frame_done cmd %h got %0d want 1", cmd, fd_cnt - f0);
            end
        end
        tests++; if (wr_wide != 0) begin fails++; $display("FAIL rand_pulse_width wide pulses %0d want 0", wr_wide); end
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_devid_read();
        test_write_read();
        test_mb_burst();
        test_abort();
        test_simultaneous();
        test_soft_reset();
        test_async_reset();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
